// File: rtl/component_delay_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : component_delay_arbiter
//  Description : Round-robin issue scheduler sharing one fixed-latency
//                pipelined unit among REQS requesters. Issues at most one
//                operand per cycle, tags it with the requester id, routes the
//                result back with a valid/id tag, limits each requester to one
//                outstanding operation and supports a synchronous flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module component_delay_arbiter #(
   parameter int   WIDTH  = 8,
   parameter int   CYCLES = 4,
   parameter int   REQS   = 4,
   localparam int  IDW    = $clog2(REQS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic [REQS-1:0]         req,
   input  logic [REQS*WIDTH-1:0]   op_in,
   output logic [REQS-1:0]         gnt,
   output logic [REQS-1:0]         busy,
   output logic [WIDTH-1:0]        unit_in,
   input  logic [WIDTH-1:0]        unit_out,
   output logic                    res_valid,
   output logic [IDW-1:0]          res_id,
   output logic [WIDTH-1:0]        res_data
);

   // Round-robin pointer and per-requester outstanding flags
   logic [IDW-1:0]   r_ptr;
   logic [REQS-1:0]  r_busy;

   // Tag pipeline running in lockstep with the shared unit
   logic [CYCLES-1:0] r_tag_v;
   logic [IDW-1:0]    r_tag_id [CYCLES];

   logic [REQS-1:0]  w_elig;
   logic [REQS-1:0]  w_gnt;
   logic             w_gnt_any;
   logic [IDW-1:0]   w_gidx;
   logic [IDW:0]     w_sum;
   logic [IDW-1:0]   w_ptr_nxt;
   logic [REQS-1:0]  w_clr;
   logic             w_res_valid;

   // Search the eligible set from the pointer upward with wrap; first hit wins.
   // Reset and flush both suppress any grant.
   always_comb begin
      w_elig    = req & ~r_busy;
      w_gnt     = '0;
      w_gnt_any = 1'b0;
      w_gidx    = '0;
      w_sum     = '0;
      if (rst && !flush) begin
         for (int k = 0; k < REQS; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(REQS)) begin
               w_sum = w_sum - (IDW+1)'(REQS);
            end
            if (!w_gnt_any && w_elig[w_sum[IDW-1:0]]) begin
               w_gnt_any = 1'b1;
               w_gidx    = w_sum[IDW-1:0];
            end
         end
      end
      if (w_gnt_any) begin
         w_gnt[w_gidx] = 1'b1;
      end
   end

   // Forward the granted requester's operand; zero when nothing is issued
   always_comb begin
      unit_in = '0;
      for (int i = 0; i < REQS; i++) begin
         if (w_gnt[i]) begin
            unit_in = unit_in | op_in[i*WIDTH +: WIDTH];
         end
      end
   end

   // Next pointer is one past the winner, wrapping at REQS
   always_comb begin
      w_ptr_nxt = (w_gidx == IDW'(REQS-1)) ? '0 : w_gidx + IDW'(1);
   end

   // Result valid is killed during a flush cycle; clear mask frees the owner
   always_comb begin
      w_res_valid = r_tag_v[CYCLES-1] & ~flush;
      w_clr       = '0;
      for (int i = 0; i < REQS; i++) begin
         w_clr[i] = w_res_valid && (r_tag_id[CYCLES-1] == IDW'(i));
      end
   end

   // Pointer advances only on a grant
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr <= '0;
      end else if (w_gnt_any) begin
         r_ptr <= w_ptr_nxt;
      end
   end

   // Busy sets on grant, clears when the result retires, all drop on flush
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy <= '0;
      end else if (flush) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy | w_gnt) & ~w_clr;
      end
   end

   // Tag shift register; flush kills every valid so stale unit data is ignored
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tag_v <= '0;
         for (int s = 0; s < CYCLES; s++) begin
            r_tag_id[s] <= '0;
         end
      end else begin
         r_tag_v[0]  <= w_gnt_any & ~flush;
         r_tag_id[0] <= w_gidx;
         for (int s = 1; s < CYCLES; s++) begin
            r_tag_v[s]  <= r_tag_v[s-1] & ~flush;
            r_tag_id[s] <= r_tag_id[s-1];
         end
      end
   end

   assign gnt       = w_gnt;
   assign busy      = r_busy;
   assign res_valid = w_res_valid;
   assign res_id    = r_tag_id[CYCLES-1];
   assign res_data  = unit_out;

endmodule
`default_nettype wire

// File: tb/tb_component_delay_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_component_delay_arbiter
//  Description : Bench for component_delay_arbiter with a reference model of
//                the issue/retire rules and a behavioural shared delay unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_component_delay_arbiter;

   localparam int WIDTH  = 8;
   localparam int CYCLES = 4;
   localparam int REQS   = 4;
   localparam int IDW    = 2;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic                  flush = 1'b0;
   logic [REQS-1:0]       req = '0;
   logic [REQS*WIDTH-1:0] op_in = '0;
   logic [REQS-1:0]       gnt;
   logic [REQS-1:0]       busy;
   logic [WIDTH-1:0]      unit_in;
   logic [WIDTH-1:0]      unit_out;
   logic                  res_valid;
   logic [IDW-1:0]        res_id;
   logic [WIDTH-1:0]      res_data;

   int checks = 0;
   int errors = 0;

   component_delay_arbiter #(.WIDTH(WIDTH), .CYCLES(CYCLES), .REQS(REQS)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .req       (req),
      .op_in     (op_in),
      .gnt       (gnt),
      .busy      (busy),
      .unit_in   (unit_in),
      .unit_out  (unit_out),
      .res_valid (res_valid),
      .res_id    (res_id),
      .res_data  (res_data)
   );

   always #5 clk = ~clk;

   // Shared fixed-latency unit: plain CYCLES-deep register chain
   logic [WIDTH-1:0] pipe [CYCLES];
   initial for (int k = 0; k < CYCLES; k++) pipe[k] = '0;
   always @(posedge clk) begin
      pipe[0] <= unit_in;
      for (int k = 1; k < CYCLES; k++) pipe[k] <= pipe[k-1];
   end
   assign unit_out = pipe[CYCLES-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: list of operations in flight with cycles remaining
   typedef struct { int id; int data; int rem; } ent_t;
   ent_t q[$];
   ent_t nq[$];
   int   m_ptr = 0;

   always @(negedge clk) begin
      logic [REQS-1:0]  mb;
      logic [REQS-1:0]  eg;
      logic [WIDTH-1:0] eu;
      int g, eid, ed, idx;
      logic erv;
      mb = '0;
      foreach (q[i]) mb[q[i].id] = 1'b1;
      g = -1;
      if (rst && !flush) begin
         for (int k = 0; k < REQS; k++) begin
            idx = (m_ptr + k) % REQS;
            if (g < 0 && req[idx] && !mb[idx]) g = idx;
         end
      end
      eg = '0;
      eu = '0;
      if (g >= 0) begin
         eg[g] = 1'b1;
         eu = op_in[g*WIDTH +: WIDTH];
      end
      erv = 1'b0; eid = 0; ed = 0;
      if (rst && !flush) begin
         foreach (q[i]) if (q[i].rem == 0) begin erv = 1'b1; eid = q[i].id; ed = q[i].data; end
      end
      chk("m_gnt", 32'(gnt), 32'(eg));
      chk("m_busy", 32'(busy), rst ? 32'(mb) : 32'h0);
      chk("m_unit_in", 32'(unit_in), 32'(eu));
      chk("m_res_valid", 32'(res_valid), 32'(erv));
      if (!rst) chk("m_res_id_rst", 32'(res_id), 32'h0);
      else if (erv) begin
         chk("m_res_id", 32'(res_id), 32'(eid));
         chk("m_res_data", 32'(res_data), 32'(ed));
      end
      // advance model across the coming edge
      if (!rst) begin
         q.delete();
         m_ptr = 0;
      end else if (flush) begin
         q.delete();
      end else begin
         nq.delete();
         foreach (q[i]) if (q[i].rem > 0) nq.push_back('{q[i].id, q[i].data, q[i].rem - 1});
         q = nq;
         if (g >= 0) begin
            q.push_back('{g, int'(eu), CYCLES - 1});
            m_ptr = (g + 1) % REQS;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
      #1;
   endtask

   task automatic setop(input int i, input logic [WIDTH-1:0] v);
      op_in[i*WIDTH +: WIDTH] = v;
   endtask

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      logic [REQS-1:0] eg_b [8];
      eg_b = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0001, 4'b0010, 4'b0000};

      // reset state
      repeat (3) step();
      look();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_res_valid", 32'(res_valid), 32'h0);
      chk("rst_res_id", 32'(res_id), 32'h0);
      step();
      rst = 1'b1;
      repeat (9) step();

      // single request from requester 2
      req = 4'b0100; setop(2, 8'h5A);
      look();
      chk("A_gnt", 32'(gnt), 32'h4);
      chk("A_unit_in", 32'(unit_in), 32'h5A);
      step(); req = '0;
      for (int k = 1; k <= 4; k++) begin
         look();
         chk("A_busy", 32'(busy), 32'h4);
         chk("A_res_valid", 32'(res_valid), 32'(k == 4));
         if (k == 4) begin
            chk("A_res_id", 32'(res_id), 32'h2);
            chk("A_res_data", 32'(res_data), 32'h5A);
         end
         step();
      end
      look();
      chk("A_busy_clear", 32'(busy), 32'h0);

      // all four requesting from reset release
      step(); rst = 1'b0;
      step(); step();
      req = 4'hF;
      for (int i = 0; i < REQS; i++) setop(i, 8'(8'h10 + i));
      rst = 1'b1;
      for (int c = 0; c < 8; c++) begin
         look();
         chk("B_gnt", 32'(gnt), 32'(eg_b[c]));
         chk("B_res_valid", 32'(res_valid), 32'(c >= 4));
         if (c >= 4) begin
            chk("B_res_id", 32'(res_id), 32'(c - 4));
            chk("B_res_data", 32'(res_data), 32'(8'h10 + c - 4));
         end
         step();
         if (c == 6) req = '0;
      end
      repeat (6) step();

      // pointer fairness
      req = 4'b1000; setop(3, 8'hC3);
      look(); chk("C_gnt3", 32'(gnt), 32'h8);
      step();
      req = 4'b0011; setop(0, 8'hA0); setop(1, 8'hA1);
      look(); chk("C_gnt0", 32'(gnt), 32'h1);
      step();
      look(); chk("C_gnt1", 32'(gnt), 32'h2);
      step(); req = '0;
      repeat (6) step();

      // flush
      req = 4'b0001; setop(0, 8'h66);
      look(); chk("D_gnt0", 32'(gnt), 32'h1);
      step();
      req = 4'b0010; setop(1, 8'h67);
      look(); chk("D_gnt1", 32'(gnt), 32'h2);
      step();
      req = 4'b0100; flush = 1'b1;
      look(); chk("D_flush_gnt", 32'(gnt), 32'h0);
      chk("D_flush_res_valid", 32'(res_valid), 32'h0);
      step();
      flush = 1'b0; req = 4'b0001; setop(0, 8'h77);
      look(); chk("D_busy_after", 32'(busy), 32'h0);
      chk("D_gnt_again", 32'(gnt), 32'h1);
      step(); req = '0;
      for (int c = 4; c <= 7; c++) begin
         look();
         chk("D_res_valid", 32'(res_valid), 32'(c == 7));
         if (c == 7) begin
            chk("D_res_id", 32'(res_id), 32'h0);
            chk("D_res_data", 32'(res_data), 32'h77);
         end
         step();
      end
      repeat (3) step();

      // reset with three operations in flight
      req = 4'hF;
      for (int i = 0; i < REQS; i++) setop(i, 8'(8'hE0 + i));
      look(); chk("E_gnt1", 32'(gnt), 32'h2); step();
      look(); chk("E_gnt2", 32'(gnt), 32'h4); step();
      look(); chk("E_gnt3", 32'(gnt), 32'h8); step();
      rst = 1'b0;
      #1;
      chk("E_async_gnt", 32'(gnt), 32'h0);
      chk("E_async_busy", 32'(busy), 32'h0);
      chk("E_async_res_valid", 32'(res_valid), 32'h0);
      chk("E_async_unit_in", 32'(unit_in), 32'h0);
      step(); step();
      rst = 1'b1; req = '0;
      for (int c = 0; c < 6; c++) begin
         look();
         chk("E_no_result", 32'(res_valid), 32'h0);
         step();
      end

      // result retire coinciding with a new grant
      req = 4'b0010; setop(1, 8'hF1);
      look(); chk("F_gnt1", 32'(gnt), 32'h2);
      step(); req = '0;
      repeat (3) step();
      req = 4'b0100; setop(2, 8'hF2);
      look();
      chk("F_res_valid", 32'(res_valid), 32'h1);
      chk("F_res_id", 32'(res_id), 32'h1);
      chk("F_res_data", 32'(res_data), 32'hF1);
      chk("F_gnt2", 32'(gnt), 32'h4);
      step(); req = '0;
      look();
      chk("F_busy", 32'(busy), 32'h4);
      repeat (6) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
